// File: rtl/matmul_pkg.sv
// Shared types and helpers for the streaming matrix-multiply engine.
package matmul_pkg;

  // Widest accumulator the saturation helper handles (ACC_W and OUT_W must stay below this).
  localparam int unsigned SAT_MAX_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_MAC    = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] data;
    logic                 clamped;
  } sat_res_t;

  // Ceiling log2, used for counter and accumulator sizing.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

  // Clamp an already sign/zero-extended accumulator value to out_w bits.
  // When out_w >= acc_w every accumulator value fits, so nothing is clamped.
  function automatic sat_res_t saturate(input logic [SAT_MAX_W-1:0] value,
                                        input int unsigned acc_w,
                                        input int unsigned out_w,
                                        input logic is_signed);
    sat_res_t res;
    logic signed [SAT_MAX_W-1:0] s_val;
    logic signed [SAT_MAX_W-1:0] s_max;
    logic signed [SAT_MAX_W-1:0] s_min;
    logic [SAT_MAX_W-1:0]        u_max;
    res.data    = value;
    res.clamped = 1'b0;
    s_val = value;
    s_max = (SAT_MAX_W'(1) << (out_w - 1)) - SAT_MAX_W'(1);
    s_min = ~s_max;
    u_max = (SAT_MAX_W'(1) << out_w) - SAT_MAX_W'(1);
    if (out_w < acc_w) begin
      if (is_signed) begin
        if (s_val > s_max) begin
          res.data    = s_max;
          res.clamped = 1'b1;
        end else if (s_val < s_min) begin
          res.data    = s_min;
          res.clamped = 1'b1;
        end
      end else if (value > u_max) begin
        res.data    = u_max;
        res.clamped = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Single multiply-accumulate lane with output saturation.
// The accumulator is registered; the saturated view of it is combinational so
// it stays stable for as long as the accumulator is held.
module matmul_mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 34,
  parameter int OUT_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_sat
);

  // One extra bit per operand lets a single signed multiplier serve both modes.
  localparam int PROD_W = 2 * DATA_W + 2;

  logic signed [DATA_W:0]   w_a_ext;
  logic signed [DATA_W:0]   w_b_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]         w_prod_acc;
  logic [ACC_W-1:0]         r_acc;
  logic                     w_fill;
  logic [SAT_MAX_W-1:0]     w_acc_ext;
  sat_res_t                 w_sat;
  logic                     w_sat_unused;

  assign w_a_ext    = {(SIGNED != 0) & i_a[DATA_W-1], i_a};
  assign w_b_ext    = {(SIGNED != 0) & i_b[DATA_W-1], i_b};
  assign w_prod     = PROD_W'(w_a_ext) * PROD_W'(w_b_ext);
  // The product always fits in ACC_W signed bits, so resizing is lossless.
  assign w_prod_acc = ACC_W'(w_prod);

  // Accumulator: clear wins over accumulate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_acc;
    end
  end

  assign w_fill       = (SIGNED != 0) & r_acc[ACC_W-1];
  assign w_acc_ext    = {{(SAT_MAX_W - ACC_W){w_fill}}, r_acc};
  assign w_sat        = saturate(w_acc_ext, ACC_W, OUT_W, SIGNED != 0);
  assign o_data       = w_sat.data[OUT_W-1:0];
  assign o_sat        = w_sat.clamped;
  assign w_sat_unused = ^w_sat.data[SAT_MAX_W-1:OUT_W];

endmodule

// File: rtl/matmul_stream_engine.sv
// Streaming NxN matrix multiply: A then B arrive row-major on the input
// stream, C leaves row-major on the output stream, one MAC per cycle.
//
//   state   | meaning
//   IDLE    | job finished or abandoned; counters cleared, moves on next clock
//   LOAD_A  | accepting A elements, beat t -> A[t/N][t%N]
//   LOAD_B  | accepting B elements, beat t -> B[t/N][t%N]
//   MAC     | k = 0..N-1, acc += A[i][k] * B[k][j]
//   OUT     | presenting C[i][j] until the consumer takes it
module matmul_stream_engine
  import matmul_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_abort,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OUT_W-1:0]  o_out_data,
  output logic              o_out_last,
  output logic              o_sat_flag,
  output logic              o_busy
);

  localparam int NN     = N * N;
  localparam int ACC_W  = 2 * DATA_W + clog2(N);
  localparam int BEAT_W = clog2(NN);
  localparam int IDX_W  = clog2(N);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

  state_t              r_state;
  state_t              w_next;
  logic [BEAT_W-1:0]   r_beat;
  logic [IDX_W-1:0]    r_i;
  logic [IDX_W-1:0]    r_j;
  logic [IDX_W-1:0]    r_k;
  logic [DATA_W-1:0]   r_a_mem [NN];
  logic [DATA_W-1:0]   r_b_mem [NN];

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_last_beat;
  logic                w_last_k;
  logic                w_last_elem;
  logic [BEAT_W-1:0]   w_a_idx;
  logic [BEAT_W-1:0]   w_b_idx;
  logic                w_acc_clr;
  logic                w_acc_en;
  logic [OUT_W-1:0]    w_mac_data;
  logic                w_mac_sat;

  // Abort masks every transfer so it wins over any handshake in the same cycle.
  assign w_in_fire   = i_in_valid & o_in_ready & ~i_abort;
  assign w_out_fire  = (r_state == ST_OUT) & i_out_ready & ~i_abort;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_last_k    = (r_k == LAST_IDX);
  assign w_last_elem = (r_i == LAST_IDX) && (r_j == LAST_IDX);

  assign w_a_idx = BEAT_W'(int'(r_i) * N + int'(r_k));
  assign w_b_idx = BEAT_W'(int'(r_k) * N + int'(r_j));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_LOAD_A;
        ST_LOAD_A: if (w_in_fire && w_last_beat) w_next = ST_LOAD_B;
        ST_LOAD_B: if (w_in_fire && w_last_beat) w_next = ST_MAC;
        ST_MAC:    if (w_last_k) w_next = ST_OUT;
        ST_OUT:    if (w_out_fire) w_next = w_last_elem ? ST_IDLE : ST_MAC;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state; C data is zero outside OUT.
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_last  = 1'b0;
    o_out_data  = '0;
    o_sat_flag  = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      ST_LOAD_A, ST_LOAD_B: o_in_ready = 1'b1;
      ST_MAC:               o_busy     = 1'b1;
      ST_OUT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        o_out_last  = w_last_elem;
        o_out_data  = w_mac_data;
        o_sat_flag  = w_mac_sat;
      end
      default: ;
    endcase
  end

  // Beat and i/j/k counters; IDLE and abort both leave everything at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
    end else if (i_abort || r_state == ST_IDLE) begin
      r_beat <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
    end else begin
      case (r_state)
        ST_LOAD_A, ST_LOAD_B: begin
          if (w_in_fire) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
        ST_MAC: r_k <= w_last_k ? '0 : r_k + 1'b1;
        ST_OUT: begin
          if (w_out_fire) begin
            r_j <= (r_j == LAST_IDX) ? '0 : r_j + 1'b1;
            if (r_j == LAST_IDX) r_i <= (r_i == LAST_IDX) ? '0 : r_i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand buffers; contents are only meaningful after a complete load.
  always_ff @(posedge i_clk) begin
    if (w_in_fire && r_state == ST_LOAD_A) r_a_mem[r_beat] <= i_in_data;
    if (w_in_fire && r_state == ST_LOAD_B) r_b_mem[r_beat] <= i_in_data;
  end

  // Clear the accumulator on entry to MAC (end of B load or C handshake).
  assign w_acc_clr = i_abort | w_out_fire |
                     ((r_state == ST_LOAD_B) & w_in_fire & w_last_beat);
  assign w_acc_en  = (r_state == ST_MAC) & ~i_abort;

  matmul_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_acc_clr),
    .i_en    (w_acc_en),
    .i_a     (r_a_mem[w_a_idx]),
    .i_b     (r_b_mem[w_b_idx]),
    .o_data  (w_mac_data),
    .o_sat   (w_mac_sat)
  );

endmodule
